// File: rtl/tcm_lsu_port.sv
// Load/store unit front end for a single-ported, read-first TCM RAM.
// Handles one request at a time: check legality, access the RAM, format the result, respond.
module tcm_lsu_port #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [31:0]           req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [31:0]           resp_rdata_o,
  output logic                  resp_err_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [31:0]           ram_data_o,
  output logic [3:0]            ram_wr_o,
  input  logic [31:0]           ram_data_i,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RDATA, S_RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_we;
  logic [2:0]            r_funct3;
  logic [1:0]            r_lo;
  logic [3:0]            r_strb;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [31:0]           r_ram_data;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic                  w_accept;
  logic                  w_illegal;
  logic [3:0]            w_strb;
  logic [31:0]           w_wdata;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_load_data;

  // Both ports transfer on a cycle where valid and ready are high at the same rising edge;
  // valid must then stay high with stable payload until that edge.
  assign w_accept = req_valid_i && req_ready_o;

  always_comb begin
    w_illegal = 1'b0;
    if (req_we_i) begin
      if (!(req_funct3_i inside {3'b000, 3'b001, 3'b010})) w_illegal = 1'b1;
    end else if (req_funct3_i inside {3'b011, 3'b110, 3'b111}) begin
      w_illegal = 1'b1;
    end
    if (req_funct3_i[1:0] == 2'b01 && req_addr_i[0]) w_illegal = 1'b1;
    if (req_funct3_i == 3'b010 && req_addr_i[1:0] != 2'b00) w_illegal = 1'b1;
    // Any address bit above the TCM window makes the access out of range.
    if ((req_addr_i >> (ADDR_WIDTH + 2)) != 32'd0) w_illegal = 1'b1;
  end

  always_comb begin
    w_strb  = 4'b1111;
    w_wdata = req_wdata_i;
    case (req_funct3_i[1:0])
      2'b00: begin
        w_strb  = 4'b0001 << req_addr_i[1:0];
        w_wdata = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        w_strb  = req_addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{req_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = ram_data_i[7:0];
    case (r_lo)
      2'd1:    w_byte = ram_data_i[15:8];
      2'd2:    w_byte = ram_data_i[23:16];
      2'd3:    w_byte = ram_data_i[31:24];
      default: ;
    endcase
    w_half = r_lo[1] ? ram_data_i[31:16] : ram_data_i[15:0];
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = ram_data_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = w_illegal ? S_RESP : S_ACCESS;
      S_ACCESS: w_next = r_we ? S_RESP : S_RDATA;
      S_RDATA:  w_next = S_RESP;
      S_RESP:   if (resp_ready_i) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = (r_state == S_IDLE);
    resp_valid_o = (r_state == S_RESP);
    ram_wr_o     = (r_state == S_ACCESS && r_we) ? r_strb : 4'b0000;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we       <= 1'b0;
      r_funct3   <= 3'd0;
      r_lo       <= 2'd0;
      r_strb     <= 4'd0;
      r_ram_addr <= '0;
      r_ram_data <= 32'd0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we     <= req_we_i;
        r_funct3 <= req_funct3_i;
        r_lo     <= req_addr_i[1:0];
        r_err    <= w_illegal;
        r_rdata  <= 32'd0;
        // Rejected requests never touch the RAM port, so its outputs keep their old values.
        if (!w_illegal) begin
          r_ram_addr <= req_addr_i[ADDR_WIDTH+1:2];
          r_strb     <= w_strb;
          if (req_we_i) r_ram_data <= w_wdata;
        end
      end
      if (r_state == S_RDATA) r_rdata <= w_load_data;
    end
  end

  assign ram_addr_o   = r_ram_addr;
  assign ram_data_o   = r_ram_data;
  assign resp_rdata_o = r_rdata;
  assign resp_err_o   = r_err;
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_tcm_lsu_port.sv
// Directed + lightly randomised bench for tcm_lsu_port with a read-first RAM model
// and an expected-response queue.
module tb_tcm_lsu_port;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [3:0]    ram_wr;
  logic [31:0]   ram_rdata;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0]   exp_q[$];
  logic [AW-1:0] last_waddr;
  logic [31:0]   mem [0:(1<<AW)-1];

  tcm_lsu_port #(.ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .ram_addr_o(ram_addr), .ram_data_o(ram_wdata), .ram_wr_o(ram_wr),
    .ram_data_i(ram_rdata), .dbg_state_o(dbg_state)
  );

  // clock / RAM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    for (int b = 0; b < 4; b++)
      if (ram_wr[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction: drive, watch the RAM port, check latency, hold, handshake.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_err,
                        input logic [31:0] exp_rdata, input logic [3:0] exp_strb,
                        input logic [31:0] exp_wdata, input int exp_lat, input int hold);
    int lat;
    int wr_cnt;
    logic [3:0]    wr_seen;
    logic [31:0]   wd_seen;
    logic [AW-1:0] a_first;
    logic [32:0]   e;
    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready), 64'(1'b1));
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    exp_q.push_back({exp_err, exp_rdata});
    if (!exp_err) last_waddr = addr[AW+1:2];
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    lat = 1; wr_cnt = 0; wr_seen = 4'b0; wd_seen = 32'd0;
    a_first = ram_addr;
    while (resp_valid !== 1'b1 && lat < 8) begin
      if (ram_wr !== 4'b0000) begin
        wr_cnt++; wr_seen = ram_wr; wd_seen = ram_wdata;
      end
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("ram_addr", 64'(a_first), 64'(last_waddr));
    chk("wr_cycles", 64'(wr_cnt), 64'((exp_strb != 4'b0) ? 1 : 0));
    chk("wr_strobe", 64'(wr_seen), 64'(exp_strb));
    if (exp_strb != 4'b0) chk("wr_data", 64'(wd_seen), 64'(exp_wdata));
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 64'(resp_valid), 64'(1'b1));
      chk("hold_ready", 64'(req_ready), 64'(1'b0));
      chk("hold_rdata", 64'(resp_rdata), 64'(exp_rdata));
      chk("hold_wr", 64'(ram_wr), 64'(4'b0));
      // A competing store while busy must be ignored.
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = 32'hBAD0BAD0;
      @(negedge clk);
    end
    resp_ready = 1'b1;
    e = exp_q.pop_front();
    chk("resp_valid", 64'(resp_valid), 64'(1'b1));
    chk("resp_rdata", 64'(resp_rdata), 64'(e[31:0]));
    chk("resp_err", 64'(resp_err), 64'(e[32]));
    chk("resp_wr", 64'(ram_wr), 64'(4'b0));
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    chk("post_valid", 64'(resp_valid), 64'(1'b0));
    chk("post_ready", 64'(req_ready), 64'(1'b1));
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  b;
    logic [31:0] a;
    int          lane;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    last_waddr = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(resp_valid), 64'(1'b0));
    chk("rst_err", 64'(resp_err), 64'(1'b0));
    chk("rst_rdata", 64'(resp_rdata), 64'(32'd0));
    chk("rst_wr", 64'(ram_wr), 64'(4'b0));
    chk("rst_addr", 64'(ram_addr), 64'(16'd0));
    chk("rst_wdata", 64'(ram_wdata), 64'(32'd0));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'(1'b1));

    // word store / load round trip
    do_req(1'b1, 3'b010, 32'h0001_0000, 32'hDEADBEEF, 1'b0, 32'h0, 4'b1111, 32'hDEADBEEF, 2, 0);
    chk("sw_word_addr", 64'(last_waddr), 64'(16'h4000));
    do_req(1'b0, 3'b010, 32'h0001_0000, 32'h0, 1'b0, 32'hDEADBEEF, 4'b0, 32'h0, 3, 0);
    // byte store, signed/unsigned byte loads
    do_req(1'b1, 3'b000, 32'h0001_0003, 32'h0000_0080, 1'b0, 32'h0, 4'b1000, 32'h80808080, 2, 0);
    do_req(1'b0, 3'b000, 32'h0001_0003, 32'h0, 1'b0, 32'hFFFFFF80, 4'b0, 32'h0, 3, 0);
    do_req(1'b0, 3'b100, 32'h0001_0003, 32'h0, 1'b0, 32'h00000080, 4'b0, 32'h0, 3, 0);
    // misaligned accesses
    do_req(1'b0, 3'b001, 32'h0001_0001, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0, 1, 0);
    do_req(1'b1, 3'b010, 32'h0001_0002, 32'h12345678, 1'b1, 32'h0, 4'b0, 32'h0, 1, 2);
    // back-pressured word load sees the merged byte
    do_req(1'b0, 3'b010, 32'h0001_0000, 32'h0, 1'b0, 32'h80ADBEEF, 4'b0, 32'h0, 3, 5);
    // out of range and illegal funct3
    do_req(1'b0, 3'b010, 32'h0004_0000, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0, 1, 0);
    do_req(1'b0, 3'b011, 32'h0001_0000, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0, 1, 0);
    do_req(1'b1, 3'b100, 32'h0001_0000, 32'h55, 1'b1, 32'h0, 4'b0, 32'h0, 1, 0);
    // upper halfword store and loads
    do_req(1'b1, 3'b001, 32'h0001_0006, 32'h1234A5A5, 1'b0, 32'h0, 4'b1100, 32'hA5A5A5A5, 2, 0);
    do_req(1'b0, 3'b001, 32'h0001_0006, 32'h0, 1'b0, 32'hFFFFA5A5, 4'b0, 32'h0, 3, 0);
    do_req(1'b0, 3'b101, 32'h0001_0006, 32'h0, 1'b0, 32'h0000A5A5, 4'b0, 32'h0, 3, 1);

    // random word + byte traffic
    for (int k = 0; k < 6; k++) begin
      a = 32'h0000_2000 + 32'($urandom_range(0, 255)) * 4;
      d = $urandom;
      b = 8'($urandom);
      lane = $urandom_range(0, 3);
      do_req(1'b1, 3'b010, a, d, 1'b0, 32'h0, 4'b1111, d, 2, 0);
      do_req(1'b1, 3'b000, a + 32'(lane), {24'hABCDEF, b}, 1'b0, 32'h0,
             4'(4'b0001 << lane), {4{b}}, 2, 0);
      do_req(1'b0, 3'b100, a + 32'(lane), 32'h0, 1'b0, {24'd0, b}, 4'b0, 32'h0, 3, 0);
      d[8*lane +: 8] = b;
      do_req(1'b0, 3'b010, a, 32'h0, 1'b0, d, 4'b0, 32'h0, 3, $urandom_range(0, 2));
    end

    // reset during the ACCESS cycle of a halfword store
    do_req(1'b1, 3'b010, 32'h0001_0004, 32'h11223344, 1'b0, 32'h0, 4'b1111, 32'h11223344, 2, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h0001_0004; req_wdata = 32'h0000BEEF;
    @(negedge clk);
    req_valid = 1'b0;
    chk("sh_access_wr", 64'(ram_wr), 64'(4'b0011));
    chk("sh_access_state", 64'(dbg_state), 64'(2'd1));
    #2 rst = 1'b1;
    #1;
    chk("abort_wr", 64'(ram_wr), 64'(4'b0));
    chk("abort_valid", 64'(resp_valid), 64'(1'b0));
    chk("abort_state", 64'(dbg_state), 64'(2'd0));
    @(negedge clk);
    rst = 1'b0;
    last_waddr = '0;
    chk("abort_ready", 64'(req_ready), 64'(1'b1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_resp", 64'(resp_valid), 64'(1'b0));
    end
    do_req(1'b0, 3'b010, 32'h0001_0004, 32'h0, 1'b0, 32'h11223344, 4'b0, 32'h0, 3, 0);

    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tcm_lsu_port.md
TCM_LSU_PORT -- requirements
Module: tcm_lsu_port

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, giving the word-address width of the attached TCM RAM port.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 req_valid_i  input  1  load/store request present.
REQ-005 req_ready_o  output  1  block can accept a request.
REQ-006 req_we_i  input  1  1 = store, 0 = load.
REQ-007 req_funct3_i  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr_i  input  32  byte address.
REQ-009 req_wdata_i  input  32  store data, right-aligned.
REQ-010 resp_valid_o  output  1  response present.
REQ-011 resp_ready_i  input  1  consumer accepts response.
REQ-012 resp_rdata_o  output  32  formatted load data; 0 for stores and errors.
REQ-013 resp_err_o  output  1  misaligned, illegal funct3 or out-of-range access.
REQ-014 ram_addr_o  output  ADDR_WIDTH  word address to RAM port.
REQ-015 ram_data_o  output  32  lane-positioned write data to RAM port.
REQ-016 ram_wr_o  output  4  byte write strobes to RAM port.
REQ-017 ram_data_i  input  32  RAM read data, valid one cycle after address is presented (read-first).

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, RDATA, RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-019 IDLE: on req_valid_i&&req_ready_o, latch request; go ACCESS if legal, else RESP with resp_err_o=1, resp_rdata_o=0, no RAM write.
REQ-020 Illegal: store funct3 not in {000,001,010}; load funct3 in {011,110,111}; H/HU with addr[0]=1; W with addr[1:0]!=0; any addr bit [31:ADDR_WIDTH+2] nonzero.
REQ-021 ACCESS (one cycle): ram_addr_o=addr[ADDR_WIDTH+1:2]; store -> ram_wr_o/ram_data_o driven, next RESP; load -> ram_wr_o=0, next RDATA.
REQ-022 Store strobes: B -> 4'b0001<<addr[1:0]; H -> 4'b0011 (addr[1]=0) or 4'b1100; W -> 4'b1111.
REQ-023 Store data: B replicated to all four lanes; H replicated to both halves; W unchanged.
REQ-024 RDATA (one cycle): select lane from ram_data_i by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W pass; register into resp_rdata_o; next RESP.
REQ-025 RESP: resp_valid_o=1 with resp_rdata_o/resp_err_o stable until resp_valid_o&&resp_ready_i, then IDLE.
REQ-026 ram_wr_o SHALL be 4'b0000 in every state except ACCESS with a store.
REQ-027 Latency (accept edge to resp_valid_o high): store 2 cycles, load 3 cycles, error 1 cycle; next request accepted no earlier than the cycle after response handshake.
REQ-028 Request inputs SHALL be ignored outside IDLE; resp_ready_i SHALL be ignored outside RESP.
REQ-029 ram_addr_o and ram_data_o SHALL hold their last values outside ACCESS/RDATA (no functional effect since ram_wr_o=0).

Reset
REQ-030 rst_i high SHALL immediately force IDLE, req_ready_o=1 after release, resp_valid_o=0, resp_err_o=0, resp_rdata_o=0, ram_wr_o=0, ram_addr_o=0, ram_data_o=0.
REQ-031 Reset asserted mid-operation SHALL abort the transaction with no further RAM write and no response.

Verification
REQ-032 SW addr 0x0001_0000 data 0xDEADBEEF, then LW same -> wr 4'b1111 at word 0x4000; load returns 0xDEADBEEF, err 0, 3-cycle latency.
REQ-033 SB addr 0x0001_0003 data 0x80 then LB/LBU same -> strobe 4'b1000, ram_data_o 0x80808080; LB 0xFFFFFF80, LBU 0x00000080.
REQ-034 LH addr 0x0001_0001 and SW addr 0x0001_0002 -> resp_err_o=1, rdata 0, ram_wr_o never nonzero, 1-cycle latency.
REQ-035 LW with resp_ready_i held 0 for 5 cycles -> resp_valid_o and data stable 5 cycles, req_ready_o=0 until handshake.
REQ-036 Load with addr bit ADDR_WIDTH+2 set (0x0004_0000 for default) -> resp_err_o=1, no RAM access.
REQ-037 rst_i asserted during ACCESS of SH -> ram_wr_o=0 immediately, resp_valid_o=0, IDLE after release.
